// File: rtl/midi_pkg.sv
// Shared MIDI constants and parser state type for the voice sequencer slice.
package midi_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL_CHG = 4'hB;
  localparam logic [3:0] PROG_CHG = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYSTEM   = 4'hF;
  localparam logic [7:0] RT_MIN   = 8'hF8;
  localparam logic [7:0] SYS_MIN  = 8'hF0;

  typedef enum logic [2:0] {IDLE, DATA1, DATA2, SKIP1, SKIP2} parse_state_t;
endpackage

// File: rtl/midi_voice_sequencer_if.sv
// Byte stream from the serial receiver into the sequencer.
interface midi_voice_sequencer_if;
    logic       BYTE_VALID;
    logic [7:0] BYTE_DATA;
    logic       FRAME_ERR;

    modport master (output BYTE_VALID, BYTE_DATA, FRAME_ERR);
    modport slave  (input  BYTE_VALID, BYTE_DATA, FRAME_ERR);
endinterface

// File: rtl/midi_voice_alloc.sv
// Voice table: retrigger match, lowest-free allocation, round-robin steal.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       msg_valid,
    input  logic                       msg_on,
    input  logic [6:0]                 msg_note,
    output logic [NUM_VOICES-1:0]      voice_act,
    output logic [NUM_VOICES-1:0][6:0] voice_note,
    output logic                       steal
);
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_VOICES-1:0] match;
    logic                  hit;
    logic                  has_free;
    logic [IW-1:0]         free_idx;
    logic [IW-1:0]         steal_ptr;

    // Inactive slots never match, so stale notes cannot retrigger or be released.
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_match
        assign match[v] = voice_act[v] && (voice_note[v] == msg_note);
    end
    assign hit = |match;

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_act[v]) begin
                has_free = 1'b1;
                free_idx = IW'(v);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            voice_act  <= '0;
            voice_note <= '0;
            steal      <= 1'b0;
            steal_ptr  <= '0;
        end else begin
            steal <= 1'b0;
            if (msg_valid) begin
                if (!msg_on) begin
                    voice_act <= voice_act & ~match;
                end else if (!hit) begin
                    if (has_free) begin
                        voice_act[free_idx]  <= 1'b1;
                        voice_note[free_idx] <= msg_note;
                    end else begin
                        voice_note[steal_ptr] <= msg_note;
                        steal                 <= 1'b1;
                        steal_ptr <= (steal_ptr == IW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/midi_voice_sequencer.sv
// MIDI byte-stream parser (channel filter, running status) feeding the voice allocator.
module midi_voice_sequencer
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter bit OMNI       = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    midi_voice_sequencer_if.slave   byte_in,
    input  logic [3:0]              CHANNEL,
    output logic                    MSG_VALID,
    output logic                    MSG_ON,
    output logic [6:0]              MSG_NOTE,
    output logic [6:0]              MSG_VEL,
    output logic [NUM_VOICES-1:0]   VOICE_ACT,
    output logic [7*NUM_VOICES-1:0] VOICE_NOTE,
    output logic                    STEAL
);
    parse_state_t state;
    logic         rs_valid;
    logic         rs_on;
    logic [6:0]   note_lat;
    logic [7:0]   b;
    logic         chan_hit;
    logic         fire;
    logic         fire_on;
    logic [NUM_VOICES-1:0][6:0] vnote;

    assign b        = byte_in.BYTE_DATA;
    assign chan_hit = OMNI || (b[3:0] == CHANNEL);
    // The allocator acts on the same edge that registers the message.
    assign fire     = byte_in.BYTE_VALID && !byte_in.FRAME_ERR && !b[7] && (state == DATA2);
    assign fire_on  = rs_on && (b[6:0] != 7'd0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            rs_valid  <= 1'b0;
            rs_on     <= 1'b0;
            note_lat  <= '0;
            MSG_VALID <= 1'b0;
            MSG_ON    <= 1'b0;
            MSG_NOTE  <= '0;
            MSG_VEL   <= '0;
        end else begin
            MSG_VALID <= 1'b0;
            if (byte_in.BYTE_VALID) begin
                if (byte_in.FRAME_ERR) begin
                    state <= IDLE;
                end else if (b >= RT_MIN) begin
                    state <= state;
                end else if (b[7]) begin
                    case (b[7:4])
                        NOTE_OFF, NOTE_ON: begin
                            rs_valid <= chan_hit;
                            rs_on    <= (b[7:4] == NOTE_ON);
                            state    <= chan_hit ? DATA1 : SKIP2;
                        end
                        PROG_CHG, CHAN_AT: begin
                            rs_valid <= 1'b0;
                            state    <= SKIP1;
                        end
                        SYSTEM: begin
                            rs_valid <= 1'b0;
                            state    <= IDLE;
                        end
                        default: begin
                            rs_valid <= 1'b0;
                            state    <= SKIP2;
                        end
                    endcase
                end else begin
                    case (state)
                        IDLE: if (rs_valid) begin
                            note_lat <= b[6:0];
                            state    <= DATA2;
                        end
                        DATA1: begin
                            note_lat <= b[6:0];
                            state    <= DATA2;
                        end
                        DATA2: begin
                            MSG_VALID <= 1'b1;
                            MSG_ON    <= fire_on;
                            MSG_NOTE  <= note_lat;
                            MSG_VEL   <= b[6:0];
                            state     <= DATA1;
                        end
                        SKIP2:   state <= SKIP1;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    midi_voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
        .CLK        (CLK),
        .RESET      (RESET),
        .msg_valid  (fire),
        .msg_on     (fire_on),
        .msg_note   (note_lat),
        .voice_act  (VOICE_ACT),
        .voice_note (vnote),
        .steal      (STEAL)
    );

    assign VOICE_NOTE = vnote;
endmodule
